// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared state encoding and sizing helpers for the serial arithmetic blocks
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Step-counter width; a single-step operation still needs a 1-bit counter.
  function automatic int cnt_width(input int nstep);
    int w;
    w = $clog2(nstep);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/full_sub_cell.sv
// rtl/full_sub_cell.sv - 1-bit full subtractor built from two half-subtractor stages
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic dif,
  output logic bor
);

  logic d1;
  logic b1;
  logic b2;

  assign d1  = a ^ b;
  assign b1  = ~a & b;
  assign dif = d1 ^ bin;
  assign b2  = ~d1 & bin;
  assign bor = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - digit-serial a - b - bin with borrow-out and valid/ready handshakes
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dif,
  output logic             bor
);

  localparam int NSTEP = WIDTH / DIGIT;
  localparam int CW    = cnt_width(NSTEP);

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_subtractor: DIGIT must divide WIDTH and both must be >= 1");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] dif_q, dif_d;
  logic             br_q, br_d;

  logic [DIGIT:0]         br_chain;
  logic [DIGIT-1:0]       d_bits;
  logic [WIDTH+DIGIT-1:0] dif_cat;

  assign br_chain[0] = br_q;

  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    full_sub_cell u_cell (
      .a   (a_q[i]),
      .b   (b_q[i]),
      .bin (br_chain[i]),
      .dif (d_bits[i]),
      .bor (br_chain[i+1])
    );
  end

  // New digit enters at the top so the last step leaves the result LSB-aligned.
  assign dif_cat = {d_bits, dif_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    dif_d   = dif_q;
    br_d    = br_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        dif_d = dif_cat[WIDTH+DIGIT-1:DIGIT];
        br_d  = br_chain[DIGIT];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(NSTEP - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      dif_q   <= '0;
      br_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dif_q   <= dif_d;
      br_q    <= br_d;
    end
  end

  // Handshake flags decode straight from state so reset drops out_valid without a clock.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign dif       = dif_q;
  assign bor       = br_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed and swept checks of serial_subtractor over several geometries
module tb_serial_subtractor;

  localparam int NDUT = 5;
  localparam int WID [NDUT] = '{8, 8, 16, 1, 16};
  localparam int DIG [NDUT] = '{1, 4, 2, 1, 16};

  logic clk;
  logic rst_n;

  logic [NDUT-1:0] iv;
  logic [NDUT-1:0] ordy;
  logic [NDUT-1:0] binv;
  logic [15:0]     a_v [NDUT];
  logic [15:0]     b_v [NDUT];

  logic [7:0]  dif0, dif1;
  logic [15:0] dif2, dif4;
  logic [0:0]  dif3;
  logic [NDUT-1:0] ir_m, ov_m, bor_m;
  logic [15:0] dif_m [NDUT];

  int n_checks;
  int n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir_m[0]),
    .a(a_v[0][7:0]), .b(b_v[0][7:0]), .bin(binv[0]),
    .out_valid(ov_m[0]), .out_ready(ordy[0]), .dif(dif0), .bor(bor_m[0]));

  serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir_m[1]),
    .a(a_v[1][7:0]), .b(b_v[1][7:0]), .bin(binv[1]),
    .out_valid(ov_m[1]), .out_ready(ordy[1]), .dif(dif1), .bor(bor_m[1]));

  serial_subtractor #(.WIDTH(16), .DIGIT(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir_m[2]),
    .a(a_v[2]), .b(b_v[2]), .bin(binv[2]),
    .out_valid(ov_m[2]), .out_ready(ordy[2]), .dif(dif2), .bor(bor_m[2]));

  serial_subtractor #(.WIDTH(1), .DIGIT(1)) u_d3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir_m[3]),
    .a(a_v[3][0:0]), .b(b_v[3][0:0]), .bin(binv[3]),
    .out_valid(ov_m[3]), .out_ready(ordy[3]), .dif(dif3), .bor(bor_m[3]));

  serial_subtractor #(.WIDTH(16), .DIGIT(16)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[4]), .in_ready(ir_m[4]),
    .a(a_v[4]), .b(b_v[4]), .bin(binv[4]),
    .out_valid(ov_m[4]), .out_ready(ordy[4]), .dif(dif4), .bor(bor_m[4]));

  assign dif_m[0] = {8'h00, dif0};
  assign dif_m[1] = {8'h00, dif1};
  assign dif_m[2] = dif2;
  assign dif_m[3] = {15'h0000, dif3};
  assign dif_m[4] = dif4;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One complete operation on DUT k: accept, latency, result, then output handshake.
  task automatic run_op(input int k, input logic [15:0] av, input logic [15:0] bv,
                        input logic bi, input bit rnd, input string tag);
    int          w, nstep, lat;
    bit          hs;
    logic [15:0] mask;
    logic [16:0] full;
    logic [15:0] exp_dif;
    logic        exp_bor;
    w     = WID[k];
    nstep = WID[k] / DIG[k];
    mask  = (w == 16) ? 16'hFFFF : 16'((17'd1 << w) - 17'd1);
    full  = {1'b0, av & mask} - {1'b0, bv & mask} - {16'h0000, bi};
    exp_dif = full[15:0] & mask;
    exp_bor = full[w];

    @(negedge clk);
    check({tag, " in_ready idle"}, ir_m[k], 1'b1);
    iv[k]   = 1'b1;
    a_v[k]  = av;
    b_v[k]  = bv;
    binv[k] = bi;
    ordy[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[k]  = 1'b0;
    a_v[k] = ~av;
    b_v[k] = ~bv;
    lat = 1;
    while (!ov_m[k] && lat < 40) begin
      check({tag, " in_ready busy"}, ir_m[k], 1'b0);
      if (rnd) ordy[k] = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, nstep + 1);
    check({tag, " dif"}, dif_m[k], exp_dif);
    check({tag, " bor"}, bor_m[k], exp_bor);

    hs = 1'b0;
    for (int i = 0; i < 60 && !hs; i++) begin
      ordy[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (!ov_m[k]) hs = 1'b1;
      else if (rnd) check({tag, " held dif"}, dif_m[k], exp_dif);
    end
    check({tag, " handshake"}, hs, 1'b1);
    check({tag, " in_ready after"}, ir_m[k], 1'b1);
    ordy[k] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    iv    = '0;
    ordy  = '1;
    binv  = '0;
    for (int i = 0; i < NDUT; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end

    repeat (3) @(negedge clk);
    check("rst in_ready", ir_m[0], 1'b1);
    check("rst out_valid", ov_m, '0);
    check("rst dif", dif_m[0], 16'h0000);
    check("rst bor", bor_m, '0);
    rst_n = 1'b1;

    run_op(0, 16'h05, 16'h03, 1'b0, 1'b0, "w8d1 5-3");
    run_op(0, 16'h03, 16'h05, 1'b0, 1'b0, "w8d1 3-5");
    run_op(0, 16'h00, 16'h00, 1'b1, 1'b0, "w8d1 0-0-1");
    run_op(1, 16'hA0, 16'h0F, 1'b1, 1'b0, "w8d4 A0-0F-1");

    // Hand-computed spot values for the directed vectors above.
    @(negedge clk);
    check("w8d4 dif const", dif_m[1], 16'h0090);
    check("w8d1 dif const", dif_m[0], 16'h00FF);
    check("w8d1 bor const", bor_m[0], 1'b1);

    // Backpressure: 0x10 - 0x20 = 0xF0 with borrow, held for 5 cycles.
    @(negedge clk);
    iv[0] = 1'b1; a_v[0] = 16'h10; b_v[0] = 16'h20; binv[0] = 1'b0; ordy[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (8) @(negedge clk);
    check("bp out_valid", ov_m[0], 1'b1);
    for (int i = 0; i < 5; i++) begin
      iv[0] = i[0]; a_v[0] = 16'h77; b_v[0] = 16'h11;
      @(posedge clk);
      @(negedge clk);
      check("bp out_valid held", ov_m[0], 1'b1);
      check("bp dif held", dif_m[0], 16'h00F0);
      check("bp bor held", bor_m[0], 1'b1);
      check("bp in_ready", ir_m[0], 1'b0);
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp release in_ready", ir_m[0], 1'b1);
    check("bp release out_valid", ov_m[0], 1'b0);

    // Reset during RUN step 3, observed without a clock edge.
    iv[0] = 1'b1; a_v[0] = 16'h5A; b_v[0] = 16'h3C; binv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("mid-run busy", ir_m[0], 1'b0);
    rst_n = 1'b0;
    #1;
    check("async rst in_ready", ir_m[0], 1'b1);
    check("async rst out_valid", ov_m[0], 1'b0);
    check("async rst dif", dif_m[0], 16'h0000);
    check("async rst bor", bor_m[0], 1'b0);
    #2;
    rst_n = 1'b1;
    run_op(0, 16'hFF, 16'h01, 1'b0, 1'b0, "post-rst FF-01");

    // Boundaries and random sweep on every geometry.
    for (int k = 0; k < NDUT; k++) begin
      run_op(k, 16'h0000, 16'hFFFF, 1'b1, 1'b1, $sformatf("k%0d 0-max-1", k));
      run_op(k, 16'hFFFF, 16'h0000, 1'b0, 1'b1, $sformatf("k%0d max-0", k));
      for (int j = 0; j < 12; j++) begin
        run_op(k, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1,
               $sformatf("k%0d rnd%0d", k, j));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Digit-serial WIDTH-bit subtractor computing dif = a - b - bin, plus final borrow-out.
- Processes DIGIT bits per clock, LSB digit first, through a chain of full-subtractor cells with a registered borrow between steps.
- Input and output use valid/ready handshakes, so it sits between pipeline stages of the team's arithmetic datapath.
- Generalises the single-bit half subtractor to arbitrary width, a borrow-in, and multi-cycle operation.

Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥ 1.
- DIGIT, 1, bits processed per cycle; must divide WIDTH. Elaboration fails otherwise.
- NSTEP (localparam), WIDTH/DIGIT, number of compute cycles.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operands a, b and bin are valid.
- in_ready, output, 1, block can accept operands.
- a, input, WIDTH, minuend.
- b, input, WIDTH, subtrahend.
- bin, input, 1, borrow-in.
- out_valid, output, 1, result is valid.
- out_ready, input, 1, downstream accepts the result.
- dif, output, WIDTH, difference modulo 2^WIDTH.
- bor, output, 1, borrow-out; 1 iff a < b + bin as unsigned values.

Behaviour:
- Reset (async assert, sync deassert by the clock domain):
  - state = IDLE, in_ready = 1, out_valid = 0.
  - dif = 0, bor = 0, step counter = 0, internal shift registers = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: capture a and b into shift registers, load the borrow register with bin, clear the step counter, go to RUN.
  - in_valid low: stay in IDLE.
- RUN:
  - in_ready = 0, out_valid = 0.
  - Each cycle, take the low DIGIT bits of a_sh and b_sh plus the borrow register.
  - Per bit i, in a ripple: d_i = a_i ^ b_i ^ br_i; br_{i+1} = (~a_i & b_i) | (~(a_i ^ b_i) & br_i).
  - Shift the DIGIT result bits into the top of the dif shift register.
  - Shift a_sh and b_sh right by DIGIT.
  - Register the final borrow; increment the counter.
  - After the step where counter == NSTEP-1, go to DONE.
- DONE:
  - out_valid = 1; dif holds the full result LSB-aligned, bor = registered borrow.
  - dif and bor stay stable while out_valid && !out_ready (backpressure can last any length of time).
  - On out_ready: go to IDLE, in_ready = 1 the next cycle.
- Latency:
  - Result is valid exactly NSTEP+1 cycles after the accept edge (accept edge → NSTEP RUN cycles → DONE).
  - Throughput is one operation per NSTEP+2 cycles when out_ready is held high.
- in_valid while busy: ignored (in_ready = 0); operands are not buffered.
- Operand inputs change during RUN/DONE: no effect on the result.
- Wrap-around: result is modulo 2^WIDTH; underflow is shown only by bor = 1.
- DIGIT == WIDTH: NSTEP = 1, one RUN cycle, 2-cycle latency.
- Reset mid-RUN or mid-DONE: immediate return to reset values; the partial result is discarded and out_valid drops asynchronously.
- No X on outputs after reset regardless of inputs.

Decomposition:
- Shared package arith_pkg:
  - state enum typedef (IDLE, RUN, DONE).
  - Function computing the step-counter width, $clog2(NSTEP) with a minimum of 1.
- Sub-module full_sub_cell, a 1-bit full subtractor:
  - Ports a, b, bin, dif, bor.
  - Built from two half-subtractor stages plus an OR on the borrows.
  - Instantiated DIGIT times in a generate loop as the combinational ripple for one step.

Test Plan:
- WIDTH=8, DIGIT=1; a=0x05, b=0x03, bin=0, out_ready=1 → out_valid 9 cycles after accept, dif=0x02, bor=0.
- WIDTH=8, DIGIT=1; a=0x03, b=0x05, bin=0 → dif=0xFE, bor=1. Then a=0x00, b=0x00, bin=1 → dif=0xFF, bor=1.
- WIDTH=8, DIGIT=4; a=0xA0, b=0x0F, bin=1 → dif=0x90, bor=0, out_valid 3 cycles after accept; in_ready stays 0 throughout.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → dif/bor/out_valid stable, in_ready=0, and in_valid pulses are ignored. Raise out_ready → next cycle IDLE, in_ready=1.
- Reset mid-operation: assert rst_n=0 during RUN step 3 → outputs at reset values with no clock edge needed. Release, issue a=0xFF, b=0x01 → dif=0xFE, bor=0.
- Randomised sweep against a reference model, WIDTH ∈ {1, 8, 16}, DIGIT ∈ {1, 2, WIDTH}, random out_ready → every result matches {bor, dif} = {1'b0, a} - b - bin.
